shift_add_mult_ctrl: RTL

- Sequential unsigned multiplier controller that time-shares a single WIDTH-bit ripple-carry adder row, built from fa cells, across WIDTH iterations.
- Low-area alternative to the combinational array multiplier. It produces the exact unsigned product used as the baseline against the approximate log multipliers.
- Operands arrive and products leave over valid/ready handshakes, so the block drops into the same test harnesses as the array multiplier.

---
 rtl/shift_add_mult_ctrl.sv | 80 ++++++++
 1 files changed

// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequential unsigned shift-add multiplier with valid/ready handshakes.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/a/b operand handshake;
//        out_valid/out_ready/product result handshake; busy high while iterating.
module fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module shift_add_mult_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   logic [1:0]       state;
   logic [WIDTH-1:0] mcand, acc_hi, acc_lo, addend, s;
   logic [WIDTH:0]   cy;
   logic [CNT_W-1:0] count;
   assign addend = acc_lo[0] ? mcand : '0;
   assign cy[0]  = 1'b0;
   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_fa
         fa u_fa (.a(acc_hi[i]), .b(addend[i]), .ci(cy[i]), .s(s[i]), .co(cy[i+1]));
      end
   endgenerate
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign busy      = state == RUN;
   // the adder carry-out becomes acc_hi's MSB after the shift, so no separate carry register is kept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mcand   <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         count   <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               mcand  <= a;
               acc_lo <= b;
               acc_hi <= '0;
               count  <= '0;
               state  <= RUN;
            end
            RUN: begin
               acc_hi <= {cy[WIDTH], s[WIDTH-1:1]};
               acc_lo <= {s[0], acc_lo[WIDTH-1:1]};
               count  <= count + CNT_W'(1);
               if (count == CNT_W'(WIDTH - 1)) begin
                  product <= {cy[WIDTH], s, acc_lo[WIDTH-1:1]};
                  state   <= DONE;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
